tlv5618_ctrl: RTL and testbench

Update controller for the dual-channel 12-bit TLV5618 DAC. It arbitrates two channel requesters (A and B) and a configuration source onto the single serial driver `tlv5618_driver`, and builds each 16-bit command word. It also sequences buffer/latch writes so that channel B never picks up stale data and paired A+B updates land simultaneously. It sits between user logic and `tlv5618_driver`; both share `clk` and `rst_n`.

---
 rtl/tlv5618_pkg.sv | 35 +++
 rtl/tlv5618_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_tlv5618_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlv5618_pkg.sv
// tlv5618_pkg
// Shared definitions for the TLV5618 update controller:
//   - R1R0 register-select codes for the four word types
//   - FSM state and job-kind enums
//   - mk_word(): packs {R1, SPD, PWR, R0, D[11:0]} into a 16-bit DAC command
package tlv5618_pkg;

   localparam logic [1:0] R1R0_CTRL = 2'b11;
   localparam logic [1:0] R1R0_B    = 2'b00;
   localparam logic [1:0] R1R0_BUF  = 2'b01;
   localparam logic [1:0] R1R0_A    = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GO,
      ST_WAIT,
      ST_GAP
   } state_t;

   // Which pending flag a running job retires when it leaves GAP
   typedef enum logic [1:0] {
      JOB_CTRL,
      JOB_BINIT,
      JOB_USER
   } job_t;

   // The two register-select bits straddle SPD/PWR in the command word
   function automatic logic [15:0] mk_word(input logic [1:0]  r1r0,
                                           input logic        spd,
                                           input logic        pwr,
                                           input logic [11:0] d12);
      return {r1r0[1], spd, pwr, r1r0[0], d12};
   endfunction

endpackage

// File: rtl/tlv5618_ctrl.sv
// tlv5618_ctrl
// Update controller for the dual-channel TLV5618 DAC. Arbitrates channel A,
// channel B and control-register rewrites onto one serial driver, builds
// each 16-bit command word and orders buffer/latch writes so B never picks
// up stale data and paired A+B updates land together.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   a_valid/a_data/a_ready  channel A request handshake (12-bit code)
//   b_valid/b_data/b_ready  channel B request handshake (12-bit code)
//   cfg_speed, cfg_pwrdn    SPD / PWR bits placed in every word
//   cfg_ref                 REF1:REF0 for the control-register write
//   cfg_update              pulse: schedule a control-register rewrite
//   upd_done                pulse when a user update is fully committed
//   busy                    high whenever the FSM is not IDLE
//   drv_set_go/data/done    start pulse, word and completion to the driver
module tlv5618_ctrl
   import tlv5618_pkg::*;
#(
   parameter int          GAP_CYC = 4,
   parameter logic [11:0] INIT_B  = 12'h000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_valid,
   input  logic [11:0] a_data,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [11:0] b_data,
   output logic        b_ready,
   input  logic        cfg_speed,
   input  logic        cfg_pwrdn,
   input  logic [1:0]  cfg_ref,
   input  logic        cfg_update,
   output logic        upd_done,
   output logic        busy,
   output logic        drv_set_go,
   output logic [15:0] drv_set_data,
   input  logic        drv_set_done
);

   localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

   state_t      state_q, state_d;
   job_t        job_q, job_d;
   logic        cfg_pend_q, cfg_pend_d;
   logic        binit_pend_q, binit_pend_d;
   logic [7:0]  gap_cnt_q, gap_cnt_d;
   logic        second_q, second_d;
   logic [15:0] second_word_q, second_word_d;
   logic [15:0] data_q, data_d;
   logic        go_q, go_d;
   logic        done_q, done_d;
   logic        user_free, a_hs, b_hs;

   // Users are only offered the bus once both init/config jobs are retired
   assign user_free = (state_q == ST_IDLE) && !cfg_pend_q && !binit_pend_q;
   assign a_ready   = user_free;
   assign b_ready   = user_free;
   assign a_hs      = a_valid & a_ready;
   assign b_hs      = b_valid & b_ready;

   assign busy         = (state_q != ST_IDLE);
   assign drv_set_go   = go_q;
   assign drv_set_data = data_q;
   assign upd_done     = done_q;

   // Next-state logic. The word is loaded on every entry to GO and then held;
   // a paired A+B request sends BUF(b) first and queues A(a) so both DAC
   // outputs move on the A word. cfg_update is merged last so a rewrite
   // requested on the very cycle a CTRL job retires is never lost.
   always_comb begin
      state_d       = state_q;
      job_d         = job_q;
      cfg_pend_d    = cfg_pend_q;
      binit_pend_d  = binit_pend_q;
      gap_cnt_d     = gap_cnt_q;
      second_d      = second_q;
      second_word_d = second_word_q;
      data_d        = data_q;
      go_d          = 1'b0;
      done_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cfg_pend_q) begin
               state_d = ST_GO;
               job_d   = JOB_CTRL;
               data_d  = mk_word(R1R0_CTRL, cfg_speed, cfg_pwrdn, {10'b0, cfg_ref});
               go_d    = 1'b1;
            end else if (binit_pend_q) begin
               state_d = ST_GO;
               job_d   = JOB_BINIT;
               data_d  = mk_word(R1R0_B, cfg_speed, cfg_pwrdn, INIT_B);
               go_d    = 1'b1;
            end else if (a_hs && b_hs) begin
               state_d       = ST_GO;
               job_d         = JOB_USER;
               data_d        = mk_word(R1R0_BUF, cfg_speed, cfg_pwrdn, b_data);
               second_d      = 1'b1;
               second_word_d = mk_word(R1R0_A, cfg_speed, cfg_pwrdn, a_data);
               go_d          = 1'b1;
            end else if (a_hs) begin
               state_d = ST_GO;
               job_d   = JOB_USER;
               data_d  = mk_word(R1R0_A, cfg_speed, cfg_pwrdn, a_data);
               go_d    = 1'b1;
            end else if (b_hs) begin
               state_d = ST_GO;
               job_d   = JOB_USER;
               data_d  = mk_word(R1R0_B, cfg_speed, cfg_pwrdn, b_data);
               go_d    = 1'b1;
            end
         end
         ST_GO: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (drv_set_done) begin
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               gap_cnt_d = 8'd0;
               if (second_q) begin
                  state_d  = ST_GO;
                  data_d   = second_word_q;
                  second_d = 1'b0;
                  go_d     = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  case (job_q)
                     JOB_CTRL:  cfg_pend_d   = 1'b0;
                     JOB_BINIT: binit_pend_d = 1'b0;
                     JOB_USER:  done_d       = 1'b1;
                     default:   ;
                  endcase
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (cfg_update) begin
         cfg_pend_d = 1'b1;
      end
   end

   // State register. Reset re-arms both init jobs and drops any job in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         job_q         <= JOB_CTRL;
         cfg_pend_q    <= 1'b1;
         binit_pend_q  <= 1'b1;
         gap_cnt_q     <= 8'd0;
         second_q      <= 1'b0;
         second_word_q <= 16'h0000;
         data_q        <= 16'h0000;
         go_q          <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         job_q         <= job_d;
         cfg_pend_q    <= cfg_pend_d;
         binit_pend_q  <= binit_pend_d;
         gap_cnt_q     <= gap_cnt_d;
         second_q      <= second_d;
         second_word_q <= second_word_d;
         data_q        <= data_d;
         go_q          <= go_d;
         done_q        <= done_d;
      end
   end

endmodule

// File: tb/tb_tlv5618_ctrl.sv
// tb_tlv5618_ctrl
// Scoreboard bench for tlv5618_ctrl. Stimulus pushes hand-computed command
// words and expected upd_done pulses into queues; a monitor pops them when
// the DUT issues drv_set_go / upd_done. A small driver model answers each go
// with done after LAT clocks, and a DAC model decodes the words it sees.
module tb_tlv5618_ctrl;

   localparam int GAP = 3;
   localparam int LAT = 10;

   logic        clk;
   logic        rst_n;
   logic        a_valid, b_valid;
   logic [11:0] a_data, b_data;
   logic        a_ready, b_ready;
   logic        cfg_speed, cfg_pwrdn, cfg_update;
   logic [1:0]  cfg_ref;
   logic        upd_done, busy;
   logic        drv_set_go, drv_set_done;
   logic [15:0] drv_set_data;

   logic [15:0] expWords[$];
   int          expDone[$];
   int          nChecks = 0;
   int          nFails  = 0;
   int          cyc = 0;
   int          lastDone = 0;
   int          doneCount = 0;
   int          initDones = 0;
   int          readyEarly = 0;
   bit          firstGo = 1'b1;
   bit          inJob = 1'b0;
   logic [15:0] curWord = 16'h0000;
   logic [11:0] dacA = 12'h000, dacB = 12'h000, dacBuf = 12'h000;

   tlv5618_ctrl #(.GAP_CYC(GAP), .INIT_B(12'h000)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
      .cfg_speed(cfg_speed), .cfg_pwrdn(cfg_pwrdn), .cfg_ref(cfg_ref),
      .cfg_update(cfg_update), .upd_done(upd_done), .busy(busy),
      .drv_set_go(drv_set_go), .drv_set_data(drv_set_data),
      .drv_set_done(drv_set_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      nChecks++;
      if (act !== req) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic failNow(input string name);
      nChecks++;
      nFails++;
      $display("[TB] FAIL %s: bound expired or event not expected", name);
   endtask

   // Driver model: done one cycle wide, LAT clocks after go; aborts on reset
   initial begin
      bit aborted;
      drv_set_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && drv_set_go) begin
            aborted = 1'b0;
            for (int i = 0; i < LAT - 1; i++) begin
               @(posedge clk);
               #1;
               if (!rst_n) begin
                  aborted = 1'b1;
                  break;
               end
            end
            if (!aborted) begin
               drv_set_done = 1'b1;
               @(posedge clk);
               #1;
               drv_set_done = 1'b0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on go/upd_done, checks spacing and stability
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            firstGo   = 1'b1;
            inJob     = 1'b0;
            initDones = 0;
         end else begin
            cyc++;
            if (drv_set_go) begin
               if (expWords.size() == 0) begin
                  failNow("unexpected drv_set_go");
               end else begin
                  curWord = expWords.pop_front();
                  checkOutput("word at go", drv_set_data, curWord);
               end
               if (!firstGo) begin
                  checkOutput("go spacing ok", (cyc - lastDone) >= GAP + 1, 1);
               end
               firstGo = 1'b0;
               inJob   = 1'b1;
            end else if (inJob && drv_set_data !== curWord) begin
               checkOutput("data held in job", drv_set_data, curWord);
            end
            if (drv_set_done && inJob) begin
               checkOutput("data at done", drv_set_data, curWord);
               case ({curWord[15], curWord[12]})
                  2'b00: begin dacB = curWord[11:0]; dacBuf = curWord[11:0]; end
                  2'b01: dacBuf = curWord[11:0];
                  2'b10: begin dacA = curWord[11:0]; dacB = dacBuf; end
                  default: ;
               endcase
               lastDone = cyc;
               doneCount++;
               initDones++;
               inJob = 1'b0;
            end
            if (upd_done) begin
               if (expDone.size() == 0) begin
                  failNow("spurious upd_done");
               end else begin
                  void'(expDone.pop_front());
                  checkOutput("upd_done delay", cyc - lastDone, GAP + 1);
               end
            end
            if (initDones < 2 && (a_ready || b_ready)) begin
               readyEarly++;
            end
         end
      end
   end

   // Waits for a handshake slot, then presents the request for one cycle and
   // records the words it should produce
   task automatic applyStimulus(input bit doA, input logic [11:0] aDat,
                                input bit doB, input logic [11:0] bDat,
                                input logic [15:0] exp0, input logic [15:0] exp1,
                                input bit twoWords);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (a_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         failNow("ready timeout");
         return;
      end
      a_valid = doA;
      a_data  = aDat;
      b_valid = doB;
      b_data  = bDat;
      expWords.push_back(exp0);
      if (twoWords) expWords.push_back(exp1);
      expDone.push_back(1);
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic waitIdle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         #1;
         if (!busy && expWords.size() == 0 && expDone.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) failNow(name);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " drv_set_go"}, drv_set_go, 0);
      checkOutput({tag, " drv_set_data"}, drv_set_data, 16'h0000);
      checkOutput({tag, " upd_done"}, upd_done, 0);
      checkOutput({tag, " busy"}, busy, 0);
      checkOutput({tag, " a_ready"}, a_ready, 0);
      checkOutput({tag, " b_ready"}, b_ready, 0);
   endtask

   initial begin
      int d0;
      rst_n      = 1'b0;
      a_valid    = 1'b0;
      b_valid    = 1'b0;
      a_data     = 12'h000;
      b_data     = 12'h000;
      cfg_speed  = 1'b0;
      cfg_pwrdn  = 1'b0;
      cfg_ref    = 2'b01;
      cfg_update = 1'b0;

      #12;
      checkResetOutputs("reset");
      expWords.push_back(16'h9001);
      expWords.push_back(16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("busy after release", busy, 1);
      waitIdle("init sequence");
      checkOutput("ready held low in init", readyEarly, 0);
      checkOutput("a_ready after init", a_ready, 1);

      $display("[TB] A-only request");
      applyStimulus(1'b1, 12'hABC, 1'b0, 12'h000, 16'h8ABC, 16'h0000, 1'b0);
      waitIdle("A-only job");
      checkOutput("dacA after A", dacA, 12'hABC);

      $display("[TB] B-only then A-only");
      applyStimulus(1'b0, 12'h000, 1'b1, 12'h123, 16'h0123, 16'h0000, 1'b0);
      waitIdle("B-only job");
      applyStimulus(1'b1, 12'h456, 1'b0, 12'h000, 16'h8456, 16'h0000, 1'b0);
      waitIdle("A after B job");
      checkOutput("dacA after A2", dacA, 12'h456);
      checkOutput("dacB kept", dacB, 12'h123);

      $display("[TB] paired A+B request");
      d0 = doneCount;
      applyStimulus(1'b1, 12'h800, 1'b1, 12'h7FF, 16'h17FF, 16'h8800, 1'b1);
      for (int i = 0; i < 200 && doneCount == d0; i++) @(negedge clk);
      #2;
      checkOutput("first word done", doneCount, d0 + 1);
      checkOutput("dacA unchanged by BUF", dacA, 12'h456);
      checkOutput("dacB unchanged by BUF", dacB, 12'h123);
      waitIdle("paired job");
      checkOutput("dacA paired", dacA, 12'h800);
      checkOutput("dacB paired", dacB, 12'h7FF);

      $display("[TB] cfg_update during A job");
      applyStimulus(1'b1, 12'h5A5, 1'b0, 12'h000, 16'h85A5, 16'h0000, 1'b0);
      repeat (4) @(negedge clk);
      cfg_ref    = 2'b10;
      cfg_update = 1'b1;
      expWords.push_back(16'h9002);
      @(negedge clk);
      cfg_update = 1'b0;
      waitIdle("A then CTRL");
      checkOutput("dacA after cfg job", dacA, 12'h5A5);

      $display("[TB] reset in WAIT");
      applyStimulus(1'b1, 12'h321, 1'b0, 12'h000, 16'h8321, 16'h0000, 1'b0);
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("mid-job reset");
      expWords.delete();
      expDone.delete();
      expWords.push_back(16'h9002);
      expWords.push_back(16'h0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      waitIdle("init after reset");
      checkOutput("dacB after reinit", dacB, 12'h000);
      checkOutput("dacA not written", dacA, 12'h5A5);

      $display("[TB] SPD and PWR set, full-scale A");
      cfg_speed = 1'b1;
      cfg_pwrdn = 1'b1;
      applyStimulus(1'b1, 12'hFFF, 1'b0, 12'h000, 16'hEFFF, 16'h0000, 1'b0);
      waitIdle("spd/pwr job");
      checkOutput("dacA full scale", dacA, 12'hFFF);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
